// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and scanner states.
// Used by vga_timing_gen and vga_result_scanner.
package vga_pkg;
  localparam int DIV       = 4;
  localparam int H_SYNC    = 96;
  localparam int H_BP_END  = 144;
  localparam int H_ACT_END = 784;
  localparam int H_TOTAL   = 800;
  localparam int V_SYNC    = 2;
  localparam int V_BP_END  = 35;
  localparam int V_ACT_END = 515;
  localparam int V_TOTAL   = 525;
  localparam int CNT_W     = 10;
  localparam int COLOR_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHOW  = 2'd2
  } state_t;
endpackage

// File: rtl/vga_result_scanner_if.sv
// vga_result_scanner_if: result memory read port.
// master = scanner, slave = result memory.
interface vga_result_scanner_if #(
  parameter int ADDR_W = 13
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );
  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel divider, h/v counters and raw sync decode.
// Outputs are undelayed; the top aligns them with the colour path.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP_END  = vga_pkg::H_BP_END,
  parameter int H_ACT_END = vga_pkg::H_ACT_END,
  parameter int H_TOTAL   = vga_pkg::H_TOTAL,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP_END  = vga_pkg::V_BP_END,
  parameter int V_ACT_END = vga_pkg::V_ACT_END,
  parameter int V_TOTAL   = vga_pkg::V_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_ce,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             HS,
  output logic             VS,
  output logic             hFree,
  output logic             vFree
);
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [CNT_W-1:0] HSE = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] HBP = CNT_W'(H_BP_END);
  localparam logic [CNT_W-1:0] HAC = CNT_W'(H_ACT_END);
  localparam logic [CNT_W-1:0] HLS = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VSE = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] VBP = CNT_W'(V_BP_END);
  localparam logic [CNT_W-1:0] VAC = CNT_W'(V_ACT_END);
  localparam logic [CNT_W-1:0] VLS = CNT_W'(V_TOTAL - 1);

  logic [DW-1:0] div;

  assign pix_ce = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else begin
      div <= pix_ce ? '0 : div + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_ce) begin
      if (hcnt == HLS) begin
        hcnt <= '0;
        vcnt <= (vcnt == VLS) ? '0 : vcnt + CNT_W'(1);
      end else begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end

  assign HS    = (hcnt >= HSE);
  assign VS    = (vcnt >= VSE);
  assign hFree = (hcnt >= HBP) && (hcnt < HAC);
  assign vFree = (vcnt >= VBP) && (vcnt < VAC);
endmodule

// File: rtl/vga_result_scanner.sv
// vga_result_scanner: shows the CNN result window on VGA once armed.
// Define VGA_RESULT_BORDER_EN to draw a green ring around the window.
module vga_result_scanner
  import vga_pkg::*;
#(
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP_END  = vga_pkg::H_BP_END,
  parameter int H_ACT_END = vga_pkg::H_ACT_END,
  parameter int H_TOTAL   = vga_pkg::H_TOTAL,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP_END  = vga_pkg::V_BP_END,
  parameter int V_ACT_END = vga_pkg::V_ACT_END,
  parameter int V_TOTAL   = vga_pkg::V_TOTAL,
  parameter int WIN_X0    = 289,
  parameter int WIN_Y0    = 199,
  parameter int WIN_W     = 62,
  parameter int WIN_H     = 82,
  parameter int ADDR_W    = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done,
  input  logic                 stage5,
  vga_result_scanner_if.master mem,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 HS,
  output logic                 VS,
  output logic                 hFree,
  output logic                 vFree,
  output logic                 busy
);
  localparam logic [CNT_W-1:0] X0 = CNT_W'(WIN_X0);
  localparam logic [CNT_W-1:0] X1 = CNT_W'(WIN_X0 + WIN_W);
  localparam logic [CNT_W-1:0] Y0 = CNT_W'(WIN_Y0);
  localparam logic [CNT_W-1:0] Y1 = CNT_W'(WIN_Y0 + WIN_H);
  localparam logic [ADDR_W-1:0] XA = ADDR_W'(WIN_X0);
  localparam logic [ADDR_W-1:0] YA = ADDR_W'(WIN_Y0);
  localparam logic [ADDR_W-1:0] WA = ADDR_W'(WIN_W);

  logic             pix_ce;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             hs_raw;
  logic             vs_raw;
  logic             hf_raw;
  logic             vf_raw;

  vga_timing_gen #(
    .H_SYNC   (H_SYNC),
    .H_BP_END (H_BP_END),
    .H_ACT_END(H_ACT_END),
    .H_TOTAL  (H_TOTAL),
    .V_SYNC   (V_SYNC),
    .V_BP_END (V_BP_END),
    .V_ACT_END(V_ACT_END),
    .V_TOTAL  (V_TOTAL)
  ) u_tg (
    .clk   (clk),
    .rst   (rst),
    .pix_ce(pix_ce),
    .hcnt  (hcnt),
    .vcnt  (vcnt),
    .HS    (hs_raw),
    .VS    (vs_raw),
    .hFree (hf_raw),
    .vFree (vf_raw)
  );

  state_t            state;
  logic              show;
  logic              frame_start;
  logic              in_win;
  logic              ring;
  logic [ADDR_W-1:0] addr;

  assign show        = (state == SHOW);
  assign busy        = show;
  assign frame_start = pix_ce && (hcnt == '0) && (vcnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (done && stage5) state <= ARMED;
        ARMED:   if (frame_start) state <= SHOW;
        SHOW:    state <= SHOW;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_win = show && (hcnt >= X0) && (hcnt < X1)
               && (vcnt >= Y0) && (vcnt < Y1);

`ifdef VGA_RESULT_BORDER_EN
  localparam logic [CNT_W-1:0] BX0 = CNT_W'(WIN_X0 - 1);
  localparam logic [CNT_W-1:0] BY0 = CNT_W'(WIN_Y0 - 1);

  // Bounding box one pixel larger than the window, minus the window.
  assign ring = show && !in_win
             && (hcnt >= BX0) && (hcnt <= X1)
             && (vcnt >= BY0) && (vcnt <= Y1);
`else
  assign ring = 1'b0;
`endif

  assign addr = (ADDR_W'(vcnt) - YA) * WA + (ADDR_W'(hcnt) - XA);

  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        ce_d;
  logic [1:0]        win_d;
  logic [1:0]        brd_d;
  logic [2:0]        hs_d;
  logic [2:0]        vs_d;
  logic [2:0]        hf_d;
  logic [2:0]        vf_d;
  logic              pix;

  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = rd_addr_q;
  assign pix         = win_d[1] & mem.rd_data;

  // Sync/free lag the counters by 3 clks to line up with r/g/b.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ce_d      <= '0;
      win_d     <= '0;
      brd_d     <= '0;
      hs_d      <= '1;
      vs_d      <= '1;
      hf_d      <= '0;
      vf_d      <= '0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
    end else begin
      rd_en_q <= pix_ce && in_win;
      if (pix_ce && in_win) rd_addr_q <= addr;
      ce_d  <= {ce_d[0], pix_ce};
      win_d <= {win_d[0], in_win};
      brd_d <= {brd_d[0], ring};
      hs_d  <= {hs_d[1:0], hs_raw};
      vs_d  <= {vs_d[1:0], vs_raw};
      hf_d  <= {hf_d[1:0], hf_raw};
      vf_d  <= {vf_d[1:0], vf_raw};
      if (ce_d[1]) begin
        r <= {COLOR_W{pix}};
        g <= {COLOR_W{pix | brd_d[1]}};
        b <= {COLOR_W{pix}};
      end
    end
  end

  assign HS    = hs_d[2];
  assign VS    = vs_d[2];
  assign hFree = hf_d[2];
  assign vFree = vf_d[2];
endmodule

// File: tb/tb_vga_result_scanner.sv
// tb_vga_result_scanner: random done/stage5 against a pixel-index model.
// Reduced raster geometry keeps whole frames short.
module tb_vga_result_scanner;
  localparam int HSY = 6;
  localparam int HBP = 10;
  localparam int HAC = 40;
  localparam int HT  = 44;
  localparam int VSY = 2;
  localparam int VBP = 4;
  localparam int VAC = 30;
  localparam int VT  = 32;
  localparam int X0  = 20;
  localparam int Y0  = 10;
  localparam int WW  = 10;
  localparam int WH  = 8;
  localparam int AW  = 13;
  localparam int FRAME = HT * VT * 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic       stage5 = 1'b0;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       HS;
  logic       VS;
  logic       hFree;
  logic       vFree;
  logic       busy;

  vga_result_scanner_if #(.ADDR_W(AW)) mif ();

  vga_result_scanner #(
    .H_SYNC(HSY), .H_BP_END(HBP), .H_ACT_END(HAC), .H_TOTAL(HT),
    .V_SYNC(VSY), .V_BP_END(VBP), .V_ACT_END(VAC), .V_TOTAL(VT),
    .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(WW), .WIN_H(WH), .ADDR_W(AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .done  (done),
    .stage5(stage5),
    .mem   (mif.master),
    .r     (r),
    .g     (g),
    .b     (b),
    .HS    (HS),
    .VS    (VS),
    .hFree (hFree),
    .vFree (vFree),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  bit mem_arr [WW*WH];

  always @(posedge clk)
    if (mif.rd_en) mif.rd_data <= mem_arr[mif.rd_addr];

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      if (errs <= 30)
        $display("FAIL %s: got %0h, expected %0h at %0t",
                 tag, got, exp, $time);
    end
  endtask

  // Model state: cycle index since reset release, FSM flags, pipeline.
  int         c;
  bit         m_armed, m_show;
  bit         pend_iw, exp_rd;
  int         pend_addr, exp_addr;
  logic [11:0] pend_col, exp_col;
  int         rd_cnt, frames_seen;
  bit         frame_show;

  task automatic model_reset();
    c = 0;
    m_armed = 0;
    m_show = 0;
    pend_iw = 0;
    exp_rd = 0;
    pend_addr = 0;
    exp_addr = 0;
    pend_col = '0;
    exp_col = '0;
    rd_cnt = 0;
    frames_seen = 0;
    frame_show = 0;
  endtask

  function automatic bit win_at(int h, int v);
    return h >= X0 && h < X0 + WW && v >= Y0 && v < Y0 + WH;
  endfunction

  function automatic bit ring_at(int h, int v);
    bit box;
    box = h >= X0 - 1 && h <= X0 + WW && v >= Y0 - 1 && v <= Y0 + WH;
    return box && !win_at(h, v);
  endfunction

  // mode 0: never done&&stage5, 1: both high, 2: fully random
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int p, hc, vc, q, qh, qv;
      bit e_hs, e_vs, e_hf, e_vf, fs;
      p = c / 4;
      hc = p % HT;
      vc = (p / HT) % VT;
      if (c >= 6 && c % 4 == 2) exp_col = pend_col;
      if (c >= 4 && c % 4 == 0) begin
        exp_rd = pend_iw;
        if (pend_iw) exp_addr = pend_addr;
      end else begin
        exp_rd = 0;
      end
      if (c >= 3) begin
        q = (c - 3) / 4;
        qh = q % HT;
        qv = (q / HT) % VT;
        e_hs = qh >= HSY;
        e_vs = qv >= VSY;
        e_hf = qh >= HBP && qh < HAC;
        e_vf = qv >= VBP && qv < VAC;
      end else begin
        e_hs = 1; e_vs = 1; e_hf = 0; e_vf = 0;
      end
      chk("HS", 32'(HS), 32'(e_hs));
      chk("VS", 32'(VS), 32'(e_vs));
      chk("hFree", 32'(hFree), 32'(e_hf));
      chk("vFree", 32'(vFree), 32'(e_vf));
      chk("busy", 32'(busy), 32'(m_show));
      chk("rd_en", 32'(mif.rd_en), 32'(exp_rd));
      chk("rd_addr", 32'(mif.rd_addr), 32'(exp_addr));
      chk("rgb", 32'({r, g, b}), 32'(exp_col));
      if (mif.rd_en === 1'b1) rd_cnt++;
      fs = (c % 4 == 3) && hc == 0 && vc == 0;
      if (c % 4 == 3) begin
        pend_iw = m_show && win_at(hc, vc);
        pend_addr = (vc - Y0) * WW + (hc - X0);
        if (pend_iw)
          pend_col = mem_arr[pend_addr] ? 12'hFFF : 12'h000;
`ifdef VGA_RESULT_BORDER_EN
        else if (m_show && ring_at(hc, vc))
          pend_col = 12'h0F0;
`endif
        else
          pend_col = 12'h000;
      end
      case (mode)
        0: begin
          done = 1'($urandom);
          stage5 = done ? 1'b0 : 1'($urandom);
        end
        1: begin
          done = 1'b1;
          stage5 = 1'b1;
        end
        default: begin
          done = 1'($urandom);
          stage5 = 1'($urandom);
        end
      endcase
      if (m_armed && fs) begin
        m_armed = 0;
        m_show = 1;
      end else if (!m_armed && !m_show && done && stage5) begin
        m_armed = 1;
      end
      if (fs) begin
        if (frames_seen > 0)
          chk("reads_per_frame", 32'(rd_cnt), frame_show ? WW * WH : 0);
        frames_seen++;
        frame_show = m_show;
        rd_cnt = 0;
      end
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    bit hit;
    foreach (mem_arr[i]) mem_arr[i] = 1'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    // idle: never armed, full frame with no reads
    run(FRAME + 5 * HT * 4, 0);
    // arm mid-frame, then random done/stage5 which must be ignored
    run(4 * HT * 4, 1);
    run(2 * FRAME, 2);
    // reach a window pixel in SHOW, then reset asynchronously
    hit = 0;
    for (int i = 0; i < FRAME && !hit; i++) begin
      int p;
      p = c / 4;
      if (m_show && win_at(p % HT, (p / HT) % VT) && c % 4 == 1) hit = 1;
      else run(1, 2);
    end
    chk("reach_window", 32'(hit), 32'd1);
    @(posedge clk);
    #2;
    done = 1'b1;
    stage5 = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_HS", 32'(HS), 32'd1);
    chk("rst_VS", 32'(VS), 32'd1);
    chk("rst_hFree", 32'(hFree), 32'd0);
    chk("rst_vFree", 32'(vFree), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(mif.rd_en), 32'd0);
    chk("rst_rd_addr", 32'(mif.rd_addr), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    run(8, 1);
    run(2 * FRAME + 100, 2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/vga_result_scanner.md
Name: vga_result_scanner

Overview:
- Downstream display stage for the CNN result buffer.
- Generates 640x480@60 VGA timing from the 100 MHz system clock, using a pixel enable every 4 clocks.
- Scans a WIN_W x WIN_H window of the 1-bit result memory and drives 4-bit r/g/b, black outside the window.
- Arms only after the CNN reports done with stage5 set, and starts showing on the next frame boundary.

Parameters:
- DIV, 4: system clocks per pixel.
- H_SYNC, 96; H_BP_END, 144; H_ACT_END, 784; H_TOTAL, 800: horizontal counter boundaries.
- V_SYNC, 2; V_BP_END, 35; V_ACT_END, 515; V_TOTAL, 525: vertical counter boundaries.
- WIN_X0, 289; WIN_Y0, 199: window origin in raw counter coordinates.
- WIN_W, 62; WIN_H, 82: window size in pixels.
- ADDR_W, 13: result memory address width.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- done  in  1  CNN finished; level signal.
- stage5  in  1  CNN final-stage flag.
- rd_en  out  1  result memory read strobe.
- rd_addr  out  ADDR_W  result memory address.
- rd_data  in  1  result pixel, valid 1 clk after rd_en.
- r, g, b  out  4 each  colour outputs.
- HS, VS  out  1  sync outputs, active-low pulses.
- hFree, vFree  out  1  horizontal / vertical active region.
- busy  out  1  high in SHOW state.

Behaviour:
- Reset (async, active-high):
  - Pixel divider, hcnt and vcnt all 0.
  - Outputs: r/g/b=0, HS=VS=1, hFree=vFree=0, rd_en=0, rd_addr=0, busy=0.
  - State IDLE.
- Pixel enable:
  - pix_ce is high for 1 clk every DIV clks; the first pulse is the 4th clk after reset release.
  - hcnt increments on pix_ce and wraps from H_TOTAL-1 to 0.
  - vcnt increments when hcnt wraps, and wraps from V_TOTAL-1 to 0.
- Timing decode (before alignment delay):
  - HS low while hcnt < H_SYNC.
  - VS low while vcnt < V_SYNC.
  - hFree while H_BP_END <= hcnt < H_ACT_END.
  - vFree while V_BP_END <= vcnt < V_ACT_END.
- FSM:
  - IDLE -> ARMED when done && stage5 are sampled high.
  - ARMED -> SHOW on the pix_ce where hcnt==0 && vcnt==0 (frame start).
  - SHOW persists until reset; a later drop of done has no effect.
  - busy = (state == SHOW).
- Window test: in_win = WIN_X0 <= hcnt < WIN_X0+WIN_W && WIN_Y0 <= vcnt < WIN_Y0+WIN_H && state==SHOW.
- Read pipeline, with t = pix_ce cycle:
  - t+1: rd_en=in_win, rd_addr=(vcnt-WIN_Y0)*WIN_W + (hcnt-WIN_X0).
    - Arithmetic is unsigned, computed at ADDR_W bits.
    - Maximum address is 5083.
    - rd_addr holds its last value when rd_en=0.
  - t+2: rd_data is valid.
  - t+3: r=g=b={4{rd_data}} if in_win was true at t; otherwise 0.
- Alignment: HS, VS, hFree and vFree are delayed by 3 clks so they align with r/g/b. Total latency from counter to colour is 3 clks.
- rd_en is a single-cycle pulse, at most once per pixel period. There are WIN_W*WIN_H = 5084 reads per frame.
- Entering SHOW mid-frame is impossible; a partial window is never drawn.
- Reset mid-frame aborts immediately. Sync restarts from counter 0 and the block re-arms from IDLE.
- done && stage5 arriving while already ARMED or SHOW is ignored.

Optional Feature:
- Macro: VGA_RESULT_BORDER_EN.
- When defined:
  - In SHOW, pixels on the ring of thickness 1 around the window output r=0, g=4'hF, b=0.
  - Ring extents: hcnt = WIN_X0-1 or WIN_X0+WIN_W, and vcnt = WIN_Y0-1 or WIN_Y0+WIN_H, within the bounding box.
  - Ring pixels do not issue a read.
  - Border colour follows the same 3-clk latency.
- When undefined: pixels outside the window are black, and the logic is absent.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_*, V_* values above);
  - the state enum IDLE/ARMED/SHOW (2 bits);
  - the colour width constant 4.
- Sub-module vga_timing_gen: divider, hcnt/vcnt counters and sync/free decode. Outputs pix_ce, hcnt, vcnt, HS, VS, hFree, vFree.
- The top module holds the FSM, address generation and the alignment pipeline.

Test Plan:
- Release reset, done=0 → HS period 3200 clks with a low width of 384 clks; VS period 1,680,000 clks; r/g/b stay 0; rd_en never asserted.
- Assert done=1 and stage5=1 at vcnt=100 → busy rises at the next hcnt=0/vcnt=0 pix_ce; no rd_en in the current frame; 5084 rd_en pulses in the next frame.
- Memory model returns rd_data=addr[0] → at hcnt=290, vcnt=199: rd_addr=1 and r=g=b=4'hF three clks after pix_ce; at hcnt=289: r=g=b=0.
- Check the last window pixel → hcnt=350, vcnt=280 gives rd_addr=5083; hcnt=351 gives no rd_en and black output.
- Assert rst mid-window during SHOW → all outputs return to reset values within the same clk; with done held high, busy returns only at the following frame start.
- With VGA_RESULT_BORDER_EN defined → hcnt=288, vcnt=250 gives g=4'hF and r=b=0 with no rd_en; without the macro, the same pixel is black.
